// File: rtl/if_fetch_controller_if.sv
// Instruction-memory request/response bus between
// the fetch controller (master) and memory (slave).
interface if_fetch_controller_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_controller.sv
// Fetch sequencer: owns the PC, issues imem requests
// and buffers {pc, instr} pairs for the IF latch.
module if_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  isBranchTaken,
  input  logic [31:0]           branchPC,
  input  logic                  stall,
  if_fetch_controller_if.master imem,
  output logic                  if_valid,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_instr
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic          req_nxt;
  logic [31:0]   addr_nxt;
  logic [31:0]   seq_addr;

  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          flush;
  logic          push;
  logic          pop;
  logic          can_issue;

  assign flush    = isBranchTaken;
  assign if_valid = (count != '0);
  assign pop      = if_valid & ~stall & ~flush;
  assign push     = (state == BUSY) & imem.imem_ack & ~flush;
  assign seq_addr = imem.imem_addr + PC_STEP;
  assign if_pc    = if_valid ? q_pc[rd_ptr] : '0;
  assign if_instr = if_valid ? q_instr[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  // Launching now must leave a slot for the reply
  assign can_issue = (count_nxt < QFULL);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = imem.imem_req;
    addr_nxt  = imem.imem_addr;
    unique case (state)
      IDLE: begin
        if (flush) begin
          pc_nxt = branchPC;
        end else if (can_issue) begin
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (imem.imem_ack) begin
          pc_nxt = flush ? branchPC : seq_addr;
          if (can_issue) begin
            addr_nxt = pc_nxt;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end else if (flush) begin
          pc_nxt    = branchPC;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (flush)
          pc_nxt = branchPC;
        if (imem.imem_ack) begin
          if (can_issue) begin
            addr_nxt  = pc_nxt;
            state_nxt = BUSY;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      imem.imem_req  <= req_nxt;
      imem.imem_addr <= addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]    <= imem.imem_addr;
          q_instr[wr_ptr] <= imem.imem_rdata;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule
